// File: rtl/abs_phase_enc_3steps.sv
// Absolute phase -> three wrapped heterodyne phases (phase1/2/3), fully stallable pipeline.
// Optional sticky input range flag range_err_o under `define ABS_PHASE_ENC_RANGE_CHK_EN.
module abs_phase_enc_3steps #(
    parameter int DATA_WIDTH = 16,
    parameter int RATIO_3TO2 = 8,
    parameter int RATIO_2TO1 = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vld_i,
    output logic                  rdy_o,
    input  logic [DATA_WIDTH-1:0] abs_phase_i,
    input  logic                  tlast_i,
    output logic                  vld_o,
    input  logic                  rdy_i,
    output logic [DATA_WIDTH-1:0] phase1_o,
    output logic [DATA_WIDTH-1:0] phase2_o,
    output logic [DATA_WIDTH-1:0] phase3_o,
    output logic                  tlast_o,
    output logic [15:0]           line_cnt_o
`ifdef ABS_PHASE_ENC_RANGE_CHK_EN
    ,
    output logic                  range_err_o
`endif
);

    function automatic bit f_ratio_ok(input int r);
        return (r >= 1) && (r <= 64) && ((r & (r - 1)) == 0);
    endfunction

    generate
        if (!f_ratio_ok(RATIO_3TO2) || !f_ratio_ok(RATIO_2TO1) ||
            (DATA_WIDTH < 8) || (DATA_WIDTH > 18)) begin : g_bad_param
            $error("abs_phase_enc_3steps: illegal DATA_WIDTH or ratio parameter");
        end
    endgenerate

    localparam int Sh3 = $clog2(RATIO_2TO1);
    localparam int Sh2 = $clog2(RATIO_2TO1 * RATIO_3TO2);
    localparam int PadW = 24 - DATA_WIDTH;

    logic                  w_en;
    logic                  r_vld_c, r_last_c;
    logic [DATA_WIDTH-1:0] r_in;
    logic                  r_vld0, r_last0;
    logic signed [23:0]    r_a0;
    logic                  r_vld1, r_last1;
    logic signed [23:0]    r_d1, r_d2, r_d3;
    logic                  r_vld2, r_last2;
    logic [15:0]           r_w1, r_w2, r_w3;
    logic                  r_vld_o, r_tlast_o;
    logic [DATA_WIDTH-1:0] r_p1, r_p2, r_p3;
    logic [15:0]           r_line_cnt;
    logic signed [23:0]    w_sh2, w_sh3;
    logic                  w_unused;

    assign w_en  = ~r_vld_o | rdy_i;
    assign rdy_o = w_en;

    // Separate signed assignments keep the shifts arithmetic.
    assign w_sh3 = r_a0 >>> Sh3;
    assign w_sh2 = r_a0 >>> Sh2;

    // The wrap discards the integer bits of every difference.
    assign w_unused = ^{r_d1[23:16], r_d2[23:16], r_d3[23:16]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_c   <= 1'b0;
            r_last_c  <= 1'b0;
            r_in      <= '0;
            r_vld0    <= 1'b0;
            r_last0   <= 1'b0;
            r_a0      <= '0;
            r_vld1    <= 1'b0;
            r_last1   <= 1'b0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_d3      <= '0;
            r_vld2    <= 1'b0;
            r_last2   <= 1'b0;
            r_w1      <= '0;
            r_w2      <= '0;
            r_w3      <= '0;
            r_vld_o   <= 1'b0;
            r_tlast_o <= 1'b0;
            r_p1      <= '0;
            r_p2      <= '0;
            r_p3      <= '0;
        end else if (w_en) begin
            r_vld_c   <= vld_i;
            r_last_c  <= tlast_i;
            r_in      <= abs_phase_i;
            r_vld0    <= r_vld_c;
            r_last0   <= r_last_c;
            r_a0      <= {r_in, {PadW{1'b0}}};
            r_vld1    <= r_vld0;
            r_last1   <= r_last0;
            r_d1      <= r_a0;
            r_d2      <= r_a0 - w_sh2;
            r_d3      <= r_a0 - w_sh3;
            r_vld2    <= r_vld1;
            r_last2   <= r_last1;
            r_w1      <= r_d1[15:0];
            r_w2      <= r_d2[15:0];
            r_w3      <= r_d3[15:0];
            r_vld_o   <= r_vld2;
            r_tlast_o <= r_last2;
            r_p1      <= {2'b00, r_w1[15 -: DATA_WIDTH-2]};
            r_p2      <= {2'b00, r_w2[15 -: DATA_WIDTH-2]};
            r_p3      <= {2'b00, r_w3[15 -: DATA_WIDTH-2]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_cnt <= '0;
        end else if (r_vld_o && rdy_i && r_tlast_o) begin
            r_line_cnt <= r_line_cnt + 16'd1;
        end
    end

    assign vld_o      = r_vld_o;
    assign tlast_o    = r_tlast_o;
    assign phase1_o   = r_p1;
    assign phase2_o   = r_p2;
    assign phase3_o   = r_p3;
    assign line_cnt_o = r_line_cnt;

`ifdef ABS_PHASE_ENC_RANGE_CHK_EN
    // Limit 2*R pi in 8QN, held in 40 bits since it can exceed the 24-bit range.
    localparam logic signed [39:0] RangeLim = 40'(2 * RATIO_2TO1 * RATIO_3TO2) <<< 15;

    logic signed [23:0] w_in_ext;
    logic signed [39:0] w_in_wide;
    logic               w_range_bad;
    logic               r_range_err;

    assign w_in_ext    = {abs_phase_i, {PadW{1'b0}}};
    assign w_in_wide   = 40'(w_in_ext);
    assign w_range_bad = vld_i & w_en & (w_in_ext[23] | (w_in_wide >= RangeLim));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_range_err <= 1'b0;
        end else if (w_range_bad) begin
            r_range_err <= 1'b1;
        end
    end

    assign range_err_o = r_range_err;
`endif

endmodule

// File: tb/tb_abs_phase_enc_3steps.sv
// Self-checking bench for abs_phase_enc_3steps: arithmetic reference model plus directed vectors.
module tb_abs_phase_enc_3steps;

    localparam int DW = 16;
    localparam int R21 = 8;
    localparam int R32 = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vld_i = 1'b0;
    logic          rdy_i = 1'b1;
    logic          tlast_i = 1'b0;
    logic [DW-1:0] abs_phase_i = '0;
    logic          rdy_o, vld_o, tlast_o;
    logic [DW-1:0] phase1_o, phase2_o, phase3_o;
    logic [15:0]   line_cnt_o;
`ifdef ABS_PHASE_ENC_RANGE_CHK_EN
    logic          range_err_o;
`endif

    abs_phase_enc_3steps #(
        .DATA_WIDTH (DW),
        .RATIO_3TO2 (R32),
        .RATIO_2TO1 (R21)
    ) dut (
`ifdef ABS_PHASE_ENC_RANGE_CHK_EN
        .range_err_o (range_err_o),
`endif
        .clk         (clk),
        .rst_n       (rst_n),
        .vld_i       (vld_i),
        .rdy_o       (rdy_o),
        .abs_phase_i (abs_phase_i),
        .tlast_i     (tlast_i),
        .vld_o       (vld_o),
        .rdy_i       (rdy_i),
        .phase1_o    (phase1_o),
        .phase2_o    (phase2_o),
        .phase3_o    (phase3_o),
        .tlast_o     (tlast_o),
        .line_cnt_o  (line_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int out_cnt = 0;
    int model_lines = 0;
    bit stress = 0;
    logic [16:0] exp_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int floordiv(input int x, input int m);
        int q;
        q = x / m;
        if ((x % m != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    // Wrapped phase of A - floor(A/div) (div=0: plain A), as 2QN with 13 fraction bits.
    function automatic logic [15:0] f_phase(input logic [15:0] a, input int div);
        int x, d;
        x = int'($signed(a)) * 256;
        d = (div == 0) ? x : x - floordiv(x, div);
        d = ((d % 65536) + 65536) % 65536;
        return 16'(d / 4);
    endfunction

    // Per-cycle compare against the model queue; outputs sampled mid-cycle.
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_p1, prev_p2, prev_p3;
    logic          prev_last;
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst_n) begin
            exp_q.delete();
            model_lines = 0;
            prev_hold = 1'b0;
            chk("reset_vld_o", vld_o, 0);
            chk("reset_line_cnt", line_cnt_o, 0);
        end else begin
            chk("rdy_o_rule", rdy_o, (!vld_o || rdy_i));
            chk("line_cnt", line_cnt_o, model_lines);
            if (prev_hold) begin
                chk("stall_stable_p1", phase1_o, prev_p1);
                chk("stall_stable_p2", phase2_o, prev_p2);
                chk("stall_stable_p3", phase3_o, prev_p3);
                chk("stall_stable_last", tlast_o, prev_last);
                chk("stall_stable_vld", vld_o, 1);
            end
            if (vld_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_output: vld_o=1 with no beat expected at %0t", $time);
                end else begin
                    e = exp_q[0];
                    chk("model_phase1", phase1_o, f_phase(e[15:0], 0));
                    chk("model_phase2", phase2_o, f_phase(e[15:0], R21 * R32));
                    chk("model_phase3", phase3_o, f_phase(e[15:0], R21));
                    chk("model_tlast", tlast_o, e[16]);
                    if (rdy_i) begin
                        void'(exp_q.pop_front());
                        out_cnt++;
                        if (e[16]) model_lines = (model_lines + 1) % 65536;
                    end
                end
            end
            if (vld_i && rdy_o) exp_q.push_back({tlast_i, abs_phase_i});
            prev_hold = vld_o && !rdy_i;
            prev_p1 = phase1_o;
            prev_p2 = phase2_o;
            prev_p3 = phase3_o;
            prev_last = tlast_o;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stress) rdy_i = ($urandom_range(0, 99) < 55);
        end
    end

    task automatic send(input logic [15:0] d, input logic last);
        bit acc;
        acc = 0;
        vld_i = 1'b1;
        abs_phase_i = d;
        tlast_i = last;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = rdy_o;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: beat 0x%0h not accepted, expected acceptance", d);
        end
        vld_i = 1'b0;
        tlast_i = 1'b0;
    endtask

    task automatic directed(input string nm, input logic [15:0] d,
                            input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
        int lat;
        lat = 0;
        send(d, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (vld_o) begin
                lat = c;
                break;
            end
        end
        chk({nm, "_latency"}, lat, 4);
        chk({nm, "_phase1"}, phase1_o, e1);
        chk({nm, "_phase2"}, phase2_o, e2);
        chk({nm, "_phase3"}, phase3_o, e3);
    endtask

    initial begin
        int base, idle_vld;
        #2;
        chk("init_vld_o", vld_o, 0);
        chk("init_tlast_o", tlast_o, 0);
        chk("init_phase1", phase1_o, 0);
        chk("init_line_cnt", line_cnt_o, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_reset", rdy_o, 1);

        // Pin the model itself with hand-derived values.
        chk("model_pin_p2", f_phase(16'h0080, 64), 16'h1F80);
        chk("model_pin_p3", f_phase(16'hFF80, 8), 16'h2400);

        directed("zero", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        directed("one", 16'h0080, 16'h2000, 16'h1F80, 16'h1C00);
        directed("hundred", 16'h3200, 16'h0000, 16'h0E00, 16'h3000);
`ifdef ABS_PHASE_ENC_RANGE_CHK_EN
        chk("range_err_clear", range_err_o, 0);
`endif
        directed("minus_one", 16'hFF80, 16'h2000, 16'h2080, 16'h2400);
`ifdef ABS_PHASE_ENC_RANGE_CHK_EN
        repeat (3) @(posedge clk);
        #1 chk("range_err_sticky", range_err_o, 1);
`endif
        repeat (3) @(posedge clk);

        // 16-beat line under random backpressure.
        base = out_cnt;
        #1 stress = 1;
        for (int i = 0; i < 16; i++) send(16'(i * 16'h0935 + 16'h0011), (i == 15));
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
        @(posedge clk);
        #2;
        stress = 0;
        rdy_i = 1'b1;
        chk("stream_beats_out", out_cnt - base, 16);
        chk("stream_queue_empty", exp_q.size(), 0);
        chk("stream_line_cnt", line_cnt_o, 1);

        // Asynchronous reset with beats in flight.
        @(posedge clk);
        #1;
        send(16'h0100, 1'b0);
        send(16'h0200, 1'b0);
        send(16'h0300, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 chk("pre_reset_vld", vld_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_vld_o", vld_o, 0);
        chk("rst_line_cnt", line_cnt_o, 0);
        chk("rst_phase1", phase1_o, 0);
        chk("rst_tlast_o", tlast_o, 0);
`ifdef ABS_PHASE_ENC_RANGE_CHK_EN
        chk("rst_range_err", range_err_o, 0);
`endif
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        directed("post_reset", 16'h0080, 16'h2000, 16'h1F80, 16'h1C00);
        idle_vld = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (vld_o) idle_vld++;
        end
        chk("post_reset_no_extra", idle_vld, 0);
        chk("post_reset_line_cnt", line_cnt_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/abs_phase_enc_3steps.md
Name: abs_phase_enc_3steps

Overview:
- Inverse of the 3-step heterodyne unwrapper. Takes a stream of absolute phase values and produces the three wrapped phases phase1, phase2 and phase3.
- The three outputs are exactly what the heterodyne decode consumes to reconstruct the input.
- Used to synthesise projector fringe phase maps and as a closed-loop stimulus source for the unwrapping pipeline.
- AXI-stream style in/out with backpressure; tlast is passed through.

Parameters:
- DATA_WIDTH, 16: width of input absolute phase and of each output phase. Legal range 8..18.
- RATIO_3TO2, 8: frequency ratio f13/f123. Must be a power of two in 1..64; any other value is an elaboration error.
- RATIO_2TO1, 8: frequency ratio f1/f13. Must be a power of two in 1..64; any other value is an elaboration error.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- vld_i  in  1  input beat valid
- rdy_o  out  1  input ready
- abs_phase_i  in  DATA_WIDTH  signed absolute phase, 8QN (1 sign, 8 int, DATA_WIDTH-9 frac), units of pi
- tlast_i  in  1  end of line marker
- vld_o  out  1  output beat valid
- rdy_i  in  1  downstream ready
- phase1_o  out  DATA_WIDTH  wrapped phase1, 2QN (1 sign, 2 int, DATA_WIDTH-3 frac), range [0,2)
- phase2_o  out  DATA_WIDTH  wrapped phase2, 2QN, range [0,2)
- phase3_o  out  DATA_WIDTH  wrapped phase3, 2QN, range [0,2)
- tlast_o  out  1  tlast aligned with output beat
- line_cnt_o  out  16  count of output beats accepted with tlast_o=1
- range_err_o  out  1  present only with ABS_PHASE_ENC_RANGE_CHK_EN

Behaviour:
- Math, with R = RATIO_2TO1*RATIO_3TO2 and A the absolute phase:
  - phase1 = wrap(A)
  - phase3 = wrap(A - A/RATIO_2TO1)
  - phase2 = wrap(A - A/R)
  - wrap(x) = x mod 2, always non-negative, also for negative A.
- Internal datapath is 24-bit signed 8QN (15 frac bits). Input is placed at the top: A24 = {abs_phase_i, (24-DATA_WIDTH) zeros}.
- Divisions are arithmetic right shifts by log2 of the ratio. Subtractions are 24-bit two's complement.
- wrap keeps bits [15:0] and zero-extends them.
- Output format is {2'b00, w[15 -: DATA_WIDTH-2]}, i.e. truncation (floor) with no rounding.
- Pipeline is 4 stages:
  - S0: register and extend input.
  - S1: shifts and subtractions.
  - S2: wrap.
  - S3: format into the output registers.
- Latency: a beat accepted at edge n is presented with vld_o=1 after edge n+4 when no stall occurs.
- Handshake:
  - Global enable en = ~vld_o | rdy_i; rdy_o = en. A beat transfers when vld_i & rdy_o.
  - All stages, including valid and tlast bits, advance only when en=1. While en=0 every register holds.
  - Outputs stay stable while vld_o=1 and rdy_i=0.
  - Bubbles (vld_i=0) propagate as invalid stages; data in invalid stages is don't-care.
- line_cnt_o increments on vld_o & rdy_i & tlast_o and wraps from 0xFFFF to 0.
- Reset (asynchronous, any time, including mid-line):
  - All stage valids, vld_o, tlast_o and line_cnt_o go to 0; phase outputs go to 0.
  - In-flight beats are discarded.
  - rdy_o is 1 from the first edge after rst_n deasserts.

Optional Feature:
- Macro ABS_PHASE_ENC_RANGE_CHK_EN.
- When defined: port range_err_o exists, resets to 0, and sets sticky on the first accepted input with A < 0 or A >= 2*R (in units of pi). Only reset clears it. The data path is unchanged.
- When undefined: the port and its logic are absent.

Test Plan (DATA_WIDTH=16, ratios 8/8, rdy_i=1 unless stated):
- abs_phase_i=0x0000 -> phase1/2/3 = 0x0000/0x0000/0x0000, vld_o exactly 4 cycles after acceptance.
- abs_phase_i=0x0080 (1.0) -> phase1=0x2000, phase2=0x1F80, phase3=0x1C00.
- abs_phase_i=0x3200 (100.0) -> phase1=0x0000, phase2=0x0E00, phase3=0x3000.
- abs_phase_i=0xFF80 (-1.0) -> phase1=0x2000, phase2=0x2080, phase3=0x2400. With the macro defined, range_err_o=1 and stays 1.
- Stream of 16 beats ending with tlast, rdy_i toggled pseudo-randomly -> outputs are in order, none lost or duplicated, outputs stable while stalled, tlast_o only on beat 16, line_cnt_o=1.
- Assert rst_n low with 3 beats in flight -> vld_o=0 and line_cnt_o=0 immediately. After release, a new beat 0x0080 produces only its own result after 4 cycles.
